// File: rtl/z80_rot_dec_pkg.sv
// Shared definitions for the RRD/RLD execution unit: FSM states, defaults,
// Z80 flag bit positions and the parity helper.
package z80_rot_dec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_ROTATE = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int IP_INC_DEFAULT = 2;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_H  = 4;
  localparam int FLAG_X  = 3;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

  // 1 when the byte holds an even number of ones
  function automatic logic parity_even(input logic [7:0] value);
    return ~(^value);
  endfunction

endpackage

// File: rtl/z80_rot_dec_alu.sv
// Combinational nibble rotate and flag generation for RLD/RRD.
// Optional macro Z80_UNDOC_FLAGS_EN: F bits 5/3 follow the new A instead of old F.
module z80_rot_dec_alu
  import z80_rot_dec_pkg::*;
(
  input  logic       left,
  input  logic [7:0] a,
  input  logic [7:0] m,
  input  logic [7:0] f,
  output logic [7:0] new_a,
  output logic [7:0] new_m,
  output logic [7:0] new_f
);

  // Rotate the three nibbles A[3:0], M[7:4], M[3:0] and derive flags from new A
  always_comb begin
    if (left) begin
      new_a = {a[7:4], m[7:4]};
      new_m = {m[3:0], a[3:0]};
    end else begin
      new_a = {a[7:4], m[3:0]};
      new_m = {a[3:0], m[7:4]};
    end
    new_f          = f;
    new_f[FLAG_S]  = new_a[7];
    new_f[FLAG_Z]  = (new_a == 8'h00);
    new_f[FLAG_H]  = 1'b0;
    new_f[FLAG_PV] = parity_even(new_a);
    new_f[FLAG_N]  = 1'b0;
    new_f[FLAG_C]  = f[FLAG_C];
`ifdef Z80_UNDOC_FLAGS_EN
    new_f[FLAG_Y]  = new_a[5];
    new_f[FLAG_X]  = new_a[3];
`else
    new_f[FLAG_Y]  = f[FLAG_Y];
    new_f[FLAG_X]  = f[FLAG_X];
`endif
  end

endmodule

// File: rtl/z80_rot_dec_exec.sv
// Execution unit for ED 67 (RRD) / ED 6F (RLD): read (HL), rotate, write back, retire A/F/IP.
// Optional macro Z80_UNDOC_FLAGS_EN selects undocumented F bits 5/3 (see z80_rot_dec_alu).
module z80_rot_dec_exec
  import z80_rot_dec_pkg::*;
#(
  parameter int INTERNAL_CYCLES = 4,
  parameter int IP_INC          = IP_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        left,
  input  logic [7:0]  reg_a_in,
  input  logic [7:0]  reg_f_in,
  input  logic [15:0] reg_hl_in,
  input  logic [15:0] ip_in,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic [7:0]  reg_a_out,
  output logic [7:0]  reg_f_out,
  output logic [15:0] ip_out
);

  localparam logic [7:0] CNT_LOAD = (INTERNAL_CYCLES > 0) ? 8'(INTERNAL_CYCLES - 1) : 8'd0;

  state_t      state;
  state_t      next_state;
  logic        left_lat;
  logic [7:0]  a_lat;
  logic [7:0]  f_lat;
  logic [7:0]  m_lat;
  logic [15:0] ip_lat;
  logic [7:0]  cnt;
  logic [7:0]  res_a;
  logic [7:0]  res_f;
  logic [7:0]  alu_m_in;
  logic [7:0]  alu_a;
  logic [7:0]  alu_m;
  logic [7:0]  alu_f;

  // In READ the ALU sees the byte on the bus so a zero-cycle rotate still has its result
  assign alu_m_in = (state == ST_READ) ? mem_rdata : m_lat;

  z80_rot_dec_alu u_alu (
    .left  (left_lat),
    .a     (a_lat),
    .m     (alu_m_in),
    .f     (f_lat),
    .new_a (alu_a),
    .new_m (alu_m),
    .new_f (alu_f)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_READ;
        else       next_state = ST_IDLE;
      end
      ST_READ: begin
        if (mem_ack) next_state = (INTERNAL_CYCLES == 0) ? ST_WRITE : ST_ROTATE;
        else         next_state = ST_READ;
      end
      ST_ROTATE: begin
        if (cnt == 8'd0) next_state = ST_WRITE;
        else             next_state = ST_ROTATE;
      end
      ST_WRITE: begin
        if (mem_ack) next_state = ST_DONE;
        else         next_state = ST_WRITE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath latches and registered bus/retire outputs, decoded from next_state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      reg_a_out <= 8'h00;
      reg_f_out <= 8'h00;
      ip_out    <= 16'h0000;
      left_lat  <= 1'b0;
      a_lat     <= 8'h00;
      f_lat     <= 8'h00;
      m_lat     <= 8'h00;
      ip_lat    <= 16'h0000;
      cnt       <= 8'h00;
      res_a     <= 8'h00;
      res_f     <= 8'h00;
    end else begin
      mem_rd <= (next_state == ST_READ);
      mem_wr <= (next_state == ST_WRITE);
      busy   <= (next_state != ST_IDLE);
      done   <= (next_state == ST_DONE);
      if ((state == ST_IDLE) && start) begin
        left_lat <= left;
        a_lat    <= reg_a_in;
        f_lat    <= reg_f_in;
        ip_lat   <= ip_in;
        mem_addr <= reg_hl_in;
      end
      if ((state == ST_READ) && mem_ack) begin
        m_lat <= mem_rdata;
        cnt   <= CNT_LOAD;
      end else if (state == ST_ROTATE) begin
        cnt <= cnt - 8'd1;
      end
      if (((state == ST_READ) && mem_ack) || (state == ST_ROTATE)) begin
        res_a     <= alu_a;
        res_f     <= alu_f;
        mem_wdata <= alu_m;
      end
      if ((state == ST_WRITE) && mem_ack) begin
        reg_a_out <= res_a;
        reg_f_out <= res_f;
        ip_out    <= ip_lat + 16'(IP_INC);
      end
    end
  end

endmodule
